// File: rtl/floor_fifo_ctrl_if.sv
// Bundle between the floor-request queue controller and its neighbours (call-button decoder, request RAM, motion controller).
// slave = the controller; master = the surrounding logic that drives requests and RAM read-back.
interface floor_fifo_ctrl_if #(
  parameter int FLOOR_W = 4,
  parameter int PTR_W   = 4
);
  // Handshake: i_push/i_pop are single-cycle strobes sampled at the rising edge;
  // there is no back-pressure, so a rejected push is reported by o_overflow or o_dup.
  logic               i_push;
  logic [FLOOR_W-1:0] i_floor;
  logic               i_pop;
  logic [FLOOR_W-1:0] i_rd_data;
  logic               o_wr_en;
  logic [FLOOR_W-1:0] o_wr_data;
  logic [PTR_W-1:0]   o_wr_pointer;
  logic [PTR_W-1:0]   o_rd_pointer;
  logic [PTR_W:0]     o_count;
  logic               o_empty;
  logic               o_full;
  logic               o_overflow;
  logic               o_dup;

  modport master (
    output i_push, i_floor, i_pop, i_rd_data,
    input  o_wr_en, o_wr_data, o_wr_pointer, o_rd_pointer, o_count,
           o_empty, o_full, o_overflow, o_dup
  );

  modport slave (
    input  i_push, i_floor, i_pop, i_rd_data,
    output o_wr_en, o_wr_data, o_wr_pointer, o_rd_pointer, o_count,
           o_empty, o_full, o_overflow, o_dup
  );
endinterface

// File: rtl/floor_fifo_ctrl.sv
// Pointer/flag controller for the elevator floor-request queue held in an external dual-port RAM.
// Define FLOOR_FIFO_DEDUP_EN to reject pushes of a floor that is already waiting in the queue.
module floor_fifo_ctrl #(
  parameter int fifo_pFLOOR_WIDTH   = 4,
  parameter int fifo_pFIFO_DEPTH    = 16,
  parameter int fifo_pPOINTER_WIDTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  floor_fifo_ctrl_if.slave  bus
);
  localparam int CW = fifo_pPOINTER_WIDTH + 1;

  logic [fifo_pPOINTER_WIDTH-1:0] r_wr_pointer;
  logic [fifo_pPOINTER_WIDTH-1:0] r_rd_pointer;
  logic [CW-1:0]                  r_count;
  logic                           r_empty;
  logic                           r_full;
  logic                           r_overflow;

  logic                           w_pop_ok;
  logic                           w_push_ok;
  logic                           w_dup;
  logic [CW-1:0]                  w_count_next;

`ifdef FLOOR_FIFO_DEDUP_EN
  localparam int NF = 2 ** fifo_pFLOOR_WIDTH;
  logic [NF-1:0] r_pending;
  logic [NF-1:0] w_pending_clr;
  logic [NF-1:0] w_pending_next;
  logic          r_dup;

  // The pop clear is applied first so a floor leaving the queue this cycle may be re-requested.
  always_comb begin
    w_pending_clr = r_pending;
    if (w_pop_ok) w_pending_clr[bus.i_rd_data] = 1'b0;
    w_dup = bus.i_push & w_pending_clr[bus.i_floor];
    w_pending_next = w_pending_clr;
    if (w_push_ok) w_pending_next[bus.i_floor] = 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_dup     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_dup     <= w_dup;
    end
  end

  assign bus.o_dup = r_dup;
`else
  logic w_unused_rd_data;
  assign w_unused_rd_data = ^bus.i_rd_data;
  assign w_dup            = 1'b0;
  assign bus.o_dup        = 1'b0;
`endif

  assign w_pop_ok  = bus.i_pop & ~r_empty;
  assign w_push_ok = bus.i_push & (~r_full | w_pop_ok) & ~w_dup;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers wrap through natural overflow since the depth is a power of two.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_wr_pointer <= '0;
      r_rd_pointer <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_pointer <= r_wr_pointer + 1'b1;
      if (w_pop_ok)  r_rd_pointer <= r_rd_pointer + 1'b1;
      r_count    <= w_count_next;
      r_empty    <= (w_count_next == '0);
      r_full     <= (w_count_next == CW'(fifo_pFIFO_DEPTH));
      r_overflow <= bus.i_push & r_full & ~w_pop_ok & ~w_dup;
    end
  end

  assign bus.o_wr_en      = w_push_ok & i_reset_n;
  assign bus.o_wr_data    = bus.i_floor;
  assign bus.o_wr_pointer = r_wr_pointer;
  assign bus.o_rd_pointer = r_rd_pointer;
  assign bus.o_count      = r_count;
  assign bus.o_empty      = r_empty;
  assign bus.o_full       = r_full;
  assign bus.o_overflow   = r_overflow;
endmodule
